// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared FSM encoding, ALU op codes and round-robin wrap helper for alu_share_arb
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] ALU_OP_ADD = 2'd0;
    localparam logic [1:0] ALU_OP_SUB = 2'd1;
    localparam logic [1:0] ALU_OP_AND = 2'd2;
    localparam logic [1:0] ALU_OP_OR  = 2'd3;

    function automatic int rr_wrap(input int id, input int n);
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first set req at or above ptr, wrapping
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             any
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [2*N_REQ-1:0] gnt_dbl;
    logic [N_REQ-1:0]   rot;
    logic [N_REQ-1:0]   rot_gnt;

    // Rotate so ptr sits at bit 0, pick the lowest set bit, then rotate back.
    always_comb begin
        req_dbl  = {req, req};
        rot      = N_REQ'(req_dbl >> ptr);
        rot_gnt  = '0;
        grant_id = '0;
        any      = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!any && rot[j]) begin
                any        = 1'b1;
                rot_gnt[j] = 1'b1;
                grant_id   = ID_W'((int'(ptr) + j) % N_REQ);
            end
        end
        gnt_dbl = {{N_REQ{1'b0}}, rot_gnt} << ptr;
        grant   = gnt_dbl[N_REQ-1:0] | gnt_dbl[2*N_REQ-1:N_REQ];
    end

endmodule

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin sharing of one external alu32bit; ALU_ARB_STATS_EN enables op_count
module alu_share_arb
    import alu_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 32,
    parameter int ID_W   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    input  logic [N_REQ-1:0]        req_c,
    input  logic [N_REQ*2-1:0]      req_ctrl,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_carry,
    output logic [DATA_W-1:0]       alu_in_a,
    output logic [DATA_W-1:0]       alu_in_b,
    output logic                    alu_in_c,
    output logic [1:0]              alu_ctrl,
    input  logic [DATA_W-1:0]       alu_out,
    input  logic                    alu_c_out,
    output logic [15:0]             op_count
);

    state_t            state, state_next;
    logic [ID_W-1:0]   rr_ptr;
    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   grant_id;
    logic              grant_any;
    logic              accept;
    logic              rsp_fire;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic              sel_c;
    logic [1:0]        sel_ctrl;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req      (req_valid),
        .ptr      (rr_ptr),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (grant_any)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        accept     = 1'b0;
        rsp_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) req_ready = grant;
                if (grant_any) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    rsp_fire   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_c    = 1'b0;
        sel_ctrl = 2'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_a    = req_a[i*DATA_W +: DATA_W];
                sel_b    = req_b[i*DATA_W +: DATA_W];
                sel_c    = req_c[i];
                sel_ctrl = req_ctrl[i*2 +: 2];
            end
        end
    end

    // ALU inputs stay frozen from accept through RESP so the result is stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            alu_in_a  <= '0;
            alu_in_b  <= '0;
            alu_in_c  <= 1'b0;
            alu_ctrl  <= 2'd0;
        end else begin
            if (accept) begin
                alu_in_a <= sel_a;
                alu_in_b <= sel_b;
                alu_in_c <= sel_c;
                alu_ctrl <= sel_ctrl;
                rsp_id   <= grant_id;
            end
            if (state == EXEC) begin
                rsp_data  <= alu_out;
                rsp_carry <= alu_c_out;
                rsp_valid <= 1'b1;
            end
            if (rsp_fire) begin
                rsp_valid <= 1'b0;
                rr_ptr    <= ID_W'(rr_wrap(int'(rsp_id), N_REQ));
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [15:0] op_cnt;

    always_ff @(posedge clk) begin
        if (rst)                               op_cnt <= 16'h0000;
        else if (rsp_fire && op_cnt != 16'hFFFF) op_cnt <= op_cnt + 16'd1;
    end

    assign op_count = op_cnt;
`else
    assign op_count = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - directed self-checking bench for alu_share_arb with a behavioural alu32bit
module tb_alu_share_arb;
    import alu_arb_pkg::*;

    localparam int N_REQ  = 2;
    localparam int DATA_W = 32;
    localparam int ID_W   = 1;
`ifdef ALU_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*DATA_W-1:0] req_a;
    logic [N_REQ*DATA_W-1:0] req_b;
    logic [N_REQ-1:0]        req_c;
    logic [N_REQ*2-1:0]      req_ctrl;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [DATA_W-1:0]       rsp_data;
    logic                    rsp_carry;
    logic [DATA_W-1:0]       alu_in_a;
    logic [DATA_W-1:0]       alu_in_b;
    logic                    alu_in_c;
    logic [1:0]              alu_ctrl;
    logic [DATA_W-1:0]       alu_out;
    logic                    alu_c_out;
    logic [15:0]             op_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_share_arb #(
        .N_REQ  (N_REQ),
        .DATA_W (DATA_W),
        .ID_W   (ID_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .req_ctrl  (req_ctrl),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .alu_in_a  (alu_in_a),
        .alu_in_b  (alu_in_b),
        .alu_in_c  (alu_in_c),
        .alu_ctrl  (alu_ctrl),
        .alu_out   (alu_out),
        .alu_c_out (alu_c_out),
        .op_count  (op_count)
    );

    // Stand-in for alu32bit.
    always_comb begin
        alu_out   = '0;
        alu_c_out = 1'b0;
        case (alu_ctrl)
            ALU_OP_ADD: {alu_c_out, alu_out} = {1'b0, alu_in_a} + {1'b0, alu_in_b} + {32'd0, alu_in_c};
            ALU_OP_SUB: {alu_c_out, alu_out} = {1'b0, alu_in_a} + {1'b0, ~alu_in_b} + {32'd0, alu_in_c};
            ALU_OP_AND: alu_out = alu_in_a & alu_in_b;
            default:    alu_out = alu_in_a | alu_in_b;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic c, input logic [1:0] op);
        req_a[i*DATA_W +: DATA_W] = a;
        req_b[i*DATA_W +: DATA_W] = b;
        req_c[i]                  = c;
        req_ctrl[i*2 +: 2]        = op;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_c     = '0;
        req_ctrl  = '0;
        rsp_ready = 1'b0;
        tick();
        tick();

        req_valid = 2'b11;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data",  rsp_data, 32'h0);
        chk("rst_alu_in_a",  alu_in_a, 32'h0);
        chk("rst_op_count",  32'(op_count), 32'h0);
        req_valid = 2'b00;
        rst       = 1'b0;
        tick();

        // Single request from requester 0.
        set_req(0, 32'h11, 32'h10, 1'b0, ALU_OP_ADD);
        rsp_ready = 1'b1;
        req_valid = 2'b01;
        #1;
        chk("single_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        #1;
        chk("single_exec_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("single_exec_ready", 32'(req_ready), 32'h0);
        chk("single_alu_in_a", alu_in_a, 32'h11);
        tick();
        chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("single_rsp_id", 32'(rsp_id), 32'h0);
        chk("single_rsp_data", rsp_data, 32'h21);
        chk("single_rsp_carry", 32'(rsp_carry), 32'h0);
        tick();
        chk("single_done", 32'(rsp_valid), 32'h0);

        // Carry out from requester 1.
        set_req(1, 32'hFFFF_FFFF, 32'h0, 1'b1, ALU_OP_ADD);
        req_valid = 2'b10;
        #1;
        chk("carry_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        tick();
        chk("carry_rsp_data", rsp_data, 32'h0);
        chk("carry_rsp_carry", 32'(rsp_carry), 32'h1);
        chk("carry_rsp_id", 32'(rsp_id), 32'h1);
        tick();

        // Contention: rr_ptr back at 0, order must be 0,1,0,1, three cycles apart.
        set_req(0, 32'h5, 32'h3, 1'b0, ALU_OP_AND);
        set_req(1, 32'h5, 32'h3, 1'b0, ALU_OP_OR);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("cont%0d_ready", k), 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            chk($sformatf("cont%0d_exec_ready", k), 32'(req_ready), 32'h0);
            tick();
            chk($sformatf("cont%0d_resp_ready", k), 32'(req_ready), 32'h0);
            chk($sformatf("cont%0d_rsp_id", k), 32'(rsp_id), 32'(k % 2));
            chk($sformatf("cont%0d_rsp_data", k), rsp_data, (k % 2 == 0) ? 32'h1 : 32'h7);
            tick();
        end

        // Backpressure: 5 stalled cycles in RESP with both requesters still valid.
        rsp_ready = 1'b0;
        set_req(0, 32'hF0, 32'h0F, 1'b0, ALU_OP_OR);
        #1;
        chk("bp_ready", 32'(req_ready), 32'h1);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_rsp_valid", k), 32'(rsp_valid), 32'h1);
            chk($sformatf("bp%0d_rsp_data", k), rsp_data, 32'hFF);
            chk($sformatf("bp%0d_rsp_id", k), 32'(rsp_id), 32'h0);
            chk($sformatf("bp%0d_req_ready", k), 32'(req_ready), 32'h0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_done", 32'(rsp_valid), 32'h0);
        chk("bp_next_grant", 32'(req_ready), 32'h2);
        chk("stats_count7", 32'(op_count), STATS ? 32'd7 : 32'd0);

        // Accept requester 1, then reset while in EXEC.
        tick();
        chk("mid_exec_ready", 32'(req_ready), 32'h0);
        rst = 1'b1;
        tick();
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rst_alu_in_a", alu_in_a, 32'h0);
        chk("mid_rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("mid_rst_op_count", 32'(op_count), 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_grant0", 32'(req_ready), 32'h1);
        req_valid = 2'b00;
        tick();
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        tick();
        chk("post_rst_idle_rsp_valid", 32'(rsp_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares one alu32bit instance between N_REQ requesters using a round-robin grant.
- Each requester presents operands, carry-in and a 2-bit op on a valid/ready request channel and gets the result back on a shared response channel tagged with its index.
- Sits between the datapath clients and the alu32bit instance; registers the ALU inputs and result so the combinational ALU path is isolated from the clients.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- DATA_W, 32, operand/result width; must match alu32bit.
- ID_W, 1, width of rsp_id; must equal clog2(N_REQ), minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high per cycle.
- req_a  in  N_REQ*DATA_W  operand A; slice i belongs to requester i.
- req_b  in  N_REQ*DATA_W  operand B, packed the same way.
- req_c  in  N_REQ  carry-in per requester.
- req_ctrl  in  N_REQ*2  ALU op per requester.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_data  out  DATA_W  registered alu_out.
- rsp_carry  out  1  registered c_out.
- alu_in_a  out  DATA_W  to alu32bit in_a.
- alu_in_b  out  DATA_W  to alu32bit in_b.
- alu_in_c  out  1  to alu32bit in_c.
- alu_ctrl  out  2  to alu32bit ctrl.
- alu_out  in  DATA_W  from alu32bit.
- alu_c_out  in  1  from alu32bit c_out.
- op_count  out  16  completed-operation count (see Optional Feature).

Behaviour:
- Clock/reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_carry=0, alu_in_a=0, alu_in_b=0, alu_in_c=0, alu_ctrl=0, op_count=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational: it is one-hot on the grant winner when any req_valid is high, else all zero.
  - Winner = first valid requester searching from rr_ptr upward, wrapping at N_REQ-1 back to 0.
  - On accept (req_valid[g] & req_ready[g]): latch that requester's a, b, c and ctrl into the alu_in_* registers, store g as rsp_id, go to EXEC.
- EXEC:
  - req_ready is all zero.
  - alu_in_* hold their values; rsp_data<=alu_out and rsp_carry<=alu_c_out are captured at the end of the cycle.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_carry are held stable until rsp_ready.
  - On rsp_valid & rsp_ready: rr_ptr<=rsp_id+1 (wraps to 0 after N_REQ-1), rsp_valid<=0, go to IDLE.
- Latency and throughput:
  - Accept at cycle T gives rsp_valid high in cycle T+2.
  - Back-to-back issue: at most one accept per 3 cycles with rsp_ready held high.
- Boundary conditions:
  - Simultaneous valids: the round-robin order is strict, so no requester waits more than N_REQ-1 grants.
  - A requester may drop req_valid before it is granted; no transaction is recorded.
  - req_valid held in EXEC or RESP: not accepted; req_ready stays 0.
  - rsp_ready low: RESP stalls indefinitely; no new grant is issued.
  - rst in any state: the in-flight transaction is discarded, and rsp_valid reads 0 in the cycle after the rst edge.
  - alu_ctrl is passed through unmodified; op decode is alu32bit's job.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined: op_count increments by 1 on each response handshake, saturates at 16'hFFFF, and clears on rst.
- Not defined: op_count is tied to 16'h0000 and the counter logic is omitted. The port exists in both builds.

Decomposition:
- Package alu_arb_pkg:
  - FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2).
  - ALU op constants ALU_OP_ADD=2'd0, ALU_OP_SUB=2'd1, ALU_OP_AND=2'd2, ALU_OP_OR=2'd3, shared with the alu32bit benches.
  - Function for rr_ptr wrap.
- Sub-module rr_arbiter:
  - Combinational round-robin priority pick.
  - Inputs: req[N_REQ], ptr[ID_W].
  - Outputs: grant one-hot, grant_id, any.
- alu_share_arb owns the FSM, operand/result registers and stats counter. alu32bit is instantiated by the parent, not inside this block.

Test Plan:
- Single request: req0 a=32'h11, b=32'h10, c=0, ctrl=ADD accepted at T -> rsp_valid at T+2, rsp_id=0, rsp_data=32'h21, rsp_carry=0.
- Contention: both valid from reset with rr_ptr=0, rsp_ready=1 -> grants in order 0,1,0,1; each rsp_id matches its grant; accepts are 3 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_data/rsp_id stable, req_ready=0 throughout, completes on the first rsp_ready=1 cycle.
- Carry out: req1 a=32'hFFFFFFFF, b=32'h0, c=1, ADD -> rsp_data=32'h0, rsp_carry=1, rsp_id=1.
- Reset mid-op: rst asserted in EXEC -> next cycle all outputs at reset values, no rsp_valid; requester 0 is granted first afterwards.
- Stats (ALU_ARB_STATS_EN defined): 7 completed transactions -> op_count=7; rst -> 0. Without the macro, op_count=0 throughout.
